// File: rtl/mem_bank_pkg.sv
// Shared types and helpers for mem_bank: FSM state encoding, byte-strobe merge, per-byte parity.
// Helpers work on a wide fixed container; callers cast their DATA_WIDTH vectors in and out.
package mem_bank_pkg;

    typedef enum logic {MB_INIT, MB_READY} mem_bank_state_e;

    localparam int MB_MAX_DW = 1024;
    localparam int MB_MAX_NB = MB_MAX_DW / 8;

    function automatic logic [MB_MAX_DW-1:0] strb_merge(input logic [MB_MAX_DW-1:0] old_w,
                                                       input logic [MB_MAX_DW-1:0] new_w,
                                                       input logic [MB_MAX_NB-1:0] strb);
        logic [MB_MAX_DW-1:0] r;
        r = old_w;
        for (int b = 0; b < MB_MAX_NB; b++)
            if (strb[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        return r;
    endfunction

    // Even parity: stored bit makes each byte plus its parity bit have an even number of ones.
    function automatic logic [MB_MAX_NB-1:0] byte_parity(input logic [MB_MAX_DW-1:0] d);
        logic [MB_MAX_NB-1:0] p;
        for (int b = 0; b < MB_MAX_NB; b++)
            p[b] = ^d[b*8 +: 8];
        return p;
    endfunction

endpackage

// File: rtl/mem_bank_if.sv
// Bus bundle for mem_bank: write port, parity injection, NUM_RD read ports and init status.
interface mem_bank_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RD     = 2
);
    logic                                 init_busy_o;
    logic                                 we_i;
    logic [ADDR_WIDTH-1:0]                waddr_i;
    logic [DATA_WIDTH-1:0]                wdata_i;
    logic [DATA_WIDTH/8-1:0]              wstrb_i;
    logic                                 perr_inj_i;
    logic [NUM_RD-1:0]                    re_i;
    logic [NUM_RD-1:0][ADDR_WIDTH-1:0]    raddr_i;
    logic [NUM_RD-1:0][DATA_WIDTH-1:0]    rdata_o;
    logic [NUM_RD-1:0]                    rvalid_o;
    logic [NUM_RD-1:0]                    rerr_o;

    modport master (
        input  init_busy_o, rdata_o, rvalid_o, rerr_o,
        output we_i, waddr_i, wdata_i, wstrb_i, perr_inj_i, re_i, raddr_i
    );

    modport slave (
        input  we_i, waddr_i, wdata_i, wstrb_i, perr_inj_i, re_i, raddr_i,
        output init_busy_o, rdata_o, rvalid_o, rerr_o
    );
endinterface

// File: rtl/mem_bank_rd_port.sv
// One registered read port: write-first forwarding mux, parity check, output registers.
module mem_bank_rd_port
    import mem_bank_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter bit PARITY_EN  = 1'b0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    re_i,
    input  logic                    hit_i,
    input  logic [DATA_WIDTH-1:0]   mem_data_i,
    input  logic [DATA_WIDTH/8-1:0] mem_par_i,
    input  logic [DATA_WIDTH-1:0]   fwd_data_i,
    input  logic [DATA_WIDTH/8-1:0] fwd_par_i,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    rvalid_o,
    output logic                    rerr_o
);
    localparam int NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] rdata_d, rdata_q;
    logic [NB-1:0]         par_d;
    logic                  rerr_d, rerr_q, rvalid_q;

    always_comb begin
        rdata_d = hit_i ? fwd_data_i : mem_data_i;
        par_d   = hit_i ? fwd_par_i  : mem_par_i;
        rerr_d  = PARITY_EN && (NB'(byte_parity(MB_MAX_DW'(rdata_d))) != par_d);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            rerr_q   <= 1'b0;
        end else begin
            rvalid_q <= re_i;
            if (re_i) begin
                rdata_q <= rdata_d;
                rerr_q  <= rerr_d;
            end
        end
    end

    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;
    assign rerr_o   = rerr_q;
endmodule

// File: rtl/mem_bank.sv
// Multi-read-port memory bank with byte-strobed writes and a post-reset clear sequence.
// Optional per-byte parity storage/checking is enabled by defining MEM_BANK_PARITY_EN.
module mem_bank
    import mem_bank_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_RD     = 2,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic      clk_i,
    input  logic      rst_i,
    mem_bank_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int NB    = DATA_WIDTH / 8;
`ifdef MEM_BANK_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    if (DATA_WIDTH % 8 != 0 || DATA_WIDTH > MB_MAX_DW) begin : g_bad_dw
        $error("mem_bank: DATA_WIDTH must be a multiple of 8 and <= MB_MAX_DW");
    end
    if (NUM_RD < 1) begin : g_bad_nrd
        $error("mem_bank: NUM_RD must be >= 1");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    mem_bank_state_e       state_q;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  busy_q;
    logic                  ready, wr_en;
    logic [DATA_WIDTH-1:0] wmerged;
    logic [NB-1:0]         wpar_merged;

    assign ready   = (state_q == MB_READY);
    assign wr_en   = ready && !rst_i && bus.we_i && (|bus.wstrb_i);
    assign cnt_d   = cnt_q + 1'b1;
    assign wmerged = DATA_WIDTH'(strb_merge(MB_MAX_DW'(mem_q[bus.waddr_i]),
                                            MB_MAX_DW'(bus.wdata_i),
                                            MB_MAX_NB'(bus.wstrb_i)));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= MB_INIT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                MB_INIT: begin
                    cnt_q <= cnt_d;
                    if (cnt_q == '1) begin
                        state_q <= MB_READY;
                        busy_q  <= 1'b0;
                    end
                end
                MB_READY: ;
                default: begin
                    state_q <= MB_INIT;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    // Reset itself leaves the array untouched; only the clear sequence rewrites it.
    always_ff @(posedge clk_i) begin
        if (!rst_i && state_q == MB_INIT)
            mem_q[cnt_q] <= INIT_VALUE;
        else if (wr_en)
            mem_q[bus.waddr_i] <= wmerged;
    end

`ifdef MEM_BANK_PARITY_EN
    logic [NB-1:0] par_q [DEPTH];
    logic [NB-1:0] wpar_new;

    // Injection flips the freshly computed parity of each strobed byte only.
    assign wpar_new    = NB'(byte_parity(MB_MAX_DW'(bus.wdata_i))) ^ {NB{bus.perr_inj_i}};
    assign wpar_merged = (par_q[bus.waddr_i] & ~bus.wstrb_i) | (wpar_new & bus.wstrb_i);

    always_ff @(posedge clk_i) begin
        if (!rst_i && state_q == MB_INIT)
            par_q[cnt_q] <= NB'(byte_parity(MB_MAX_DW'(INIT_VALUE)));
        else if (wr_en)
            par_q[bus.waddr_i] <= wpar_merged;
    end
`else
    logic unused_perr_inj;
    assign unused_perr_inj = bus.perr_inj_i;
    assign wpar_merged     = '0;
`endif

    logic [NUM_RD-1:0][DATA_WIDTH-1:0] rdata;
    logic [NUM_RD-1:0]                 rvalid, rerr;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic          hit;
        logic [NB-1:0] mem_par;

        assign hit = wr_en && (bus.raddr_i[p] == bus.waddr_i);
`ifdef MEM_BANK_PARITY_EN
        assign mem_par = par_q[bus.raddr_i[p]];
`else
        assign mem_par = '0;
`endif

        mem_bank_rd_port #(
            .DATA_WIDTH (DATA_WIDTH),
            .PARITY_EN  (PARITY_EN)
        ) u_rd (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .re_i       (ready && bus.re_i[p]),
            .hit_i      (hit),
            .mem_data_i (mem_q[bus.raddr_i[p]]),
            .mem_par_i  (mem_par),
            .fwd_data_i (wmerged),
            .fwd_par_i  (wpar_merged),
            .rdata_o    (rdata[p]),
            .rvalid_o   (rvalid[p]),
            .rerr_o     (rerr[p])
        );
    end

    assign bus.rdata_o     = rdata;
    assign bus.rvalid_o    = rvalid;
    assign bus.rerr_o      = rerr;
    assign bus.init_busy_o = busy_q;
endmodule

// File: doc/mem_bank.md
Name: mem_bank

Overview:
- Next-generation parametrised memory bank: one synchronous write port with byte strobes, NUM_RD independent registered read ports, and a hardware clear sequence after reset.
- Write-first forwarding on same-cycle read/write address collisions.
- Used as register-file/scratchpad storage where multiple consumers read one shared array.

Parameters:
- ADDR_WIDTH, 8, address width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 32, entry width; must be a multiple of 8 (elaboration-time assertion).
- NUM_RD, 2, number of read ports; must be >= 1.
- INIT_VALUE, '0, DATA_WIDTH-bit value written to every entry during the clear sequence.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- init_busy_o  output  1  high while the clear sequence runs.
- we_i  input  1  write enable.
- waddr_i  input  ADDR_WIDTH  write address.
- wdata_i  input  DATA_WIDTH  write data.
- wstrb_i  input  DATA_WIDTH/8  byte write strobes; bit b enables byte b.
- perr_inj_i  input  1  parity error injection; ignored when the optional feature is off.
- re_i  input  NUM_RD  per-port read enable.
- raddr_i  input  NUM_RD x ADDR_WIDTH  per-port read address.
- rdata_o  output  NUM_RD x DATA_WIDTH  per-port registered read data.
- rvalid_o  output  NUM_RD  per-port read-data-valid pulse.
- rerr_o  output  NUM_RD  per-port parity error; qualified by rvalid_o.

Behaviour:
- State machine has two states: MB_INIT and MB_READY.
- Reset (rst_i=1 at an edge):
  - State goes to MB_INIT, clear counter goes to 0.
  - rdata_o = 0, rvalid_o = 0, rerr_o = 0, init_busy_o = 1.
  - Memory contents are not modified by reset itself.
- MB_INIT:
  - Each cycle, writes INIT_VALUE (parity consistent) to entry[counter] and increments the counter.
  - After writing entry 2**ADDR_WIDTH-1, moves to MB_READY; init_busy_o falls on that same edge.
  - Clear takes exactly 2**ADDR_WIDTH cycles after rst_i deasserts.
  - we_i and re_i are ignored; rvalid_o stays 0.
- Reset mid-init restarts the clear sequence from counter 0.
- MB_READY write:
  - When we_i=1, for each byte b with wstrb_i[b]=1, entry[waddr_i] byte b <= wdata_i byte b.
  - Bytes with wstrb_i[b]=0 are unchanged.
  - we_i=1 with wstrb_i=0 is a no-op.
- MB_READY read, per port p:
  - When re_i[p]=1, on the next edge rdata_o[p] <= entry[raddr_i[p]] and rvalid_o[p] <= 1. Latency is 1 cycle.
  - When re_i[p]=0, rvalid_o[p] <= 0 and rdata_o[p] holds its previous value.
- Collision (write-first):
  - If re_i[p] and we_i are both high with raddr_i[p]==waddr_i, rdata_o[p] returns the strobe-merged result: new bytes where wstrb_i is set, old bytes elsewhere.
  - Any number of ports may read the same address in the same cycle.
- Read ports are fully independent; there is no back-pressure.
- Addresses wrap naturally at ADDR_WIDTH bits; there is no out-of-range case.

Optional Feature:
- Macro: MEM_BANK_PARITY_EN.
- Defined:
  - One even-parity bit is stored per byte and updated per strobed byte on write.
  - If perr_inj_i=1 during a write, the stored parity of every strobed byte is inverted.
  - On read, rerr_o[p] <= 1 when any byte's recomputed parity mismatches its stored parity.
  - Forwarded collision data reports the newly computed (and possibly injected) parity.
  - Clear writes correct parity.
- Undefined: no parity storage; rerr_o tied to 0; perr_inj_i unused.

Decomposition:
- Package mem_bank_pkg contains:
  - typedef enum mem_bank_state_e {MB_INIT, MB_READY}.
  - Function strb_merge(old, new, strb) for byte-strobe merge.
  - Function byte_parity(data) returning per-byte parity bits.
- Sub-module mem_bank_rd_port: one instance per read port (generate loop).
  - Contains the output registers, collision forwarding mux and parity check.
- The top level owns the array, the write logic and the init FSM.

Test Plan (ADDR_WIDTH=4, DATA_WIDTH=32, NUM_RD=2, INIT_VALUE=32'hDEAD_BEEF):
- Pulse rst_i for 1 cycle -> init_busy_o high exactly 16 cycles; reads on both ports of addresses 0..15 afterwards return 32'hDEAD_BEEF with rvalid_o one cycle after re_i.
- Assert rst_i at init cycle 7 and keep re_i/we_i high during init -> clear restarts (16 more busy cycles); no rvalid_o pulse; an attempted write of 32'h1234_5678 to addr 3 is not stored.
- Write addr 5 = 32'h1122_3344 with wstrb_i=4'b1111, then wdata_i=32'hAABB_CCDD with wstrb_i=4'b0101 -> read returns 32'h11BB_33DD.
- Same cycle: write addr 9 = 32'hCAFE_F00D (wstrb_i=4'b0011, old value DEAD_BEEF), port0 reads addr 9, port1 reads addr 2 -> port0 returns 32'hDEAD_F00D, port1 returns 32'hDEAD_BEEF, both rvalid_o=1.
- Assert re_i for 1 cycle then hold it low for 3 cycles -> rvalid_o pulses once; rdata_o holds its value for the 3 idle cycles.
- With MEM_BANK_PARITY_EN defined: write addr 1 with perr_inj_i=1, wstrb_i=4'b0001 -> read of addr 1 gives rerr_o=1; a read of addr 4 gives rerr_o=0; without the macro, rerr_o=0 in both cases.
